// File: rtl/jtframe_pocket_pkg.sv
// Shared constants for the Pocket audio output stage.
// Sample conversion helper lives here so the top and bench agree on it.
package jtframe_pocket_pkg;

  localparam int BCK_DIV     = 4;
  localparam int SLOT_BITS   = 32;
  localparam int SND_W       = 16;
  localparam int FRAME_CNT_W = 8;

  localparam logic [SND_W-1:0] OFFSET_FLIP = 16'h8000;

  localparam int PH_W  = $clog2(BCK_DIV);
  localparam int POS_W = $clog2(SLOT_BITS);
  localparam int IDX_W = $clog2(SND_W);

  function automatic logic [SND_W-1:0] snd_conv(
    input logic [SND_W-1:0] x,
    input logic             is_signed
  );
    return is_signed ? x : (x ^ OFFSET_FLIP);
  endfunction

endpackage

// File: rtl/jtframe_pocket_i2s_ser.sv
// Single-channel slot serializer: slot position to data bit,
// MSB one bit after the word-select edge, zero padding elsewhere.
module jtframe_pocket_i2s_ser
  import jtframe_pocket_pkg::*;
(
  input  logic [SND_W-1:0] i_word,
  input  logic [POS_W-1:0] i_pos,
  output logic             o_bit
);

  logic [IDX_W-1:0] w_idx;
  logic             w_in_word;

  assign w_idx = IDX_W'(POS_W'(SND_W) - i_pos);

  assign w_in_word = (i_pos != '0) &&
                     (i_pos <= POS_W'(SND_W));

  always_comb begin
    o_bit = 1'b0;
    if (w_in_word) begin
      o_bit = i_word[w_idx];
    end
  end

endmodule

// File: rtl/jtframe_pocket_i2s.sv
// Pocket I2S output: clk/4 bit clock, 64-bit frames, 16-bit samples
// in 32-bit slots, double-buffered with zero-order hold.
module jtframe_pocket_i2s
  import jtframe_pocket_pkg::*;
#(
  parameter logic SIGNED_SND = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SND_W-1:0] snd_left,
  input  logic [SND_W-1:0] snd_right,
  input  logic             snd_sample,
  input  logic             mute,
  output logic             audio_bck,
  output logic             audio_lrck,
  output logic             audio_dac,
  output logic             frame_st
);

  logic [FRAME_CNT_W-1:0] r_cnt;
  logic [FRAME_CNT_W-1:0] w_cnt_nx;

  logic [SND_W-1:0] r_hold_l;
  logic [SND_W-1:0] r_hold_r;
  logic             r_valid;
  logic [SND_W-1:0] r_sh_l;
  logic [SND_W-1:0] r_sh_r;

  logic r_bck;
  logic r_lrck;
  logic r_dac;
  logic r_fst;

  logic             w_load;
  logic             w_fall;
  logic             w_ch;
  logic [POS_W-1:0] w_pos;
  logic [SND_W-1:0] w_word;
  logic             w_bit;

  // Outputs are registered from the next count so they line up
  // with the count value they are visible during.
  assign w_cnt_nx = r_cnt + FRAME_CNT_W'(1);
  assign w_load   = &r_cnt;
  assign w_fall   = (w_cnt_nx[PH_W-1:0] == '0);
  assign w_ch     = w_cnt_nx[FRAME_CNT_W-1];
  assign w_pos    = w_cnt_nx[FRAME_CNT_W-2 -: POS_W];
  assign w_word   = w_ch ? r_sh_r : r_sh_l;

  jtframe_pocket_i2s_ser u_ser (
    .i_word (w_word),
    .i_pos  (w_pos),
    .o_bit  (w_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_bck  <= 1'b0;
      r_lrck <= 1'b0;
      r_dac  <= 1'b0;
      r_fst  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nx;
      r_bck <= w_cnt_nx[PH_W-1];
      r_fst <= w_load;
      if (w_fall) begin
        r_lrck <= w_ch;
        r_dac  <= w_bit;
      end
    end
  end

  // Shift words take the old hold on a coincident strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_l <= '0;
      r_hold_r <= '0;
      r_valid  <= 1'b0;
      r_sh_l   <= '0;
      r_sh_r   <= '0;
    end else begin
      if (snd_sample) begin
        r_hold_l <= snd_conv(snd_left, SIGNED_SND);
        r_hold_r <= snd_conv(snd_right, SIGNED_SND);
        r_valid  <= 1'b1;
      end
      if (w_load) begin
        r_sh_l <= (r_valid && !mute) ? r_hold_l : '0;
        r_sh_r <= (r_valid && !mute) ? r_hold_r : '0;
      end
    end
  end

  assign audio_bck  = r_bck;
  assign audio_lrck = r_lrck;
  assign audio_dac  = r_dac;
  assign frame_st   = r_fst;

endmodule

// File: tb/tb_jtframe_pocket_i2s.sv
// Bench for jtframe_pocket_i2s: signed and offset-binary instances
// share stimulus; a frame monitor decodes the serial line per frame.
module tb_jtframe_pocket_i2s;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] snd_left = '0;
  logic [15:0] snd_right = '0;
  logic        snd_sample = 1'b0;
  logic        mute = 1'b0;

  logic s_bck, s_lrck, s_dac, s_fst;
  logic u_bck, u_lrck, u_dac, u_fst;

  always #5 clk = ~clk;

  jtframe_pocket_i2s #(.SIGNED_SND(1'b1)) u_s (
    .clk        (clk),
    .rst_n      (rst_n),
    .snd_left   (snd_left),
    .snd_right  (snd_right),
    .snd_sample (snd_sample),
    .mute       (mute),
    .audio_bck  (s_bck),
    .audio_lrck (s_lrck),
    .audio_dac  (s_dac),
    .frame_st   (s_fst)
  );

  jtframe_pocket_i2s #(.SIGNED_SND(1'b0)) u_u (
    .clk        (clk),
    .rst_n      (rst_n),
    .snd_left   (snd_left),
    .snd_right  (snd_right),
    .snd_sample (snd_sample),
    .mute       (mute),
    .audio_bck  (u_bck),
    .audio_lrck (u_lrck),
    .audio_dac  (u_dac),
    .frame_st   (u_fst)
  );

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
    logic        on;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  // Reference frame position, independent of the DUT.
  logic [7:0] tc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tc <= '0;
    else        tc <= tc + 8'd1;
  end

  function automatic logic [15:0] word_at(
    input logic [63:0] b,
    input int          base
  );
    logic [15:0] w;
    for (int i = 0; i < 16; i++) w[15-i] = b[base+i];
    return w;
  endfunction

  function automatic logic pad_or(input logic [63:0] b);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 64; i++)
      if (!((i >= 1 && i <= 16) || (i >= 33 && i <= 48)))
        r = r | b[i];
    return r;
  endfunction

  bit          mon_en = 0;
  bit          collecting = 0;
  logic [63:0] bits_s, bits_u;
  bit          lr_bad, bck_bad, fst_bad;
  exp_t        e;
  logic [15:0] xsl, xsr, xul, xur;

  always @(negedge clk) begin
    if (!rst_n) begin
      collecting = 0;
    end else begin
      if (tc == 8'd0) begin
        collecting = mon_en;
        bits_s = '0;
        bits_u = '0;
        lr_bad = 0;
        bck_bad = 0;
        fst_bad = 0;
      end
      if (collecting) begin
        if (tc[1:0] == 2'd0) begin
          bits_s[tc[7:2]] = s_dac;
          bits_u[tc[7:2]] = u_dac;
        end
        if (s_lrck !== tc[7] || u_lrck !== tc[7]) lr_bad = 1;
        if (s_bck !== tc[1] || u_bck !== tc[1]) bck_bad = 1;
        if (s_fst !== (tc == 8'd0) || u_fst !== (tc == 8'd0))
          fst_bad = 1;
        if (tc == 8'd255) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: frame seen at %0t, required an expectation", $time);
          end else begin
            e   = sb.pop_front();
            xsl = e.on ? e.l : 16'h0000;
            xsr = e.on ? e.r : 16'h0000;
            xul = e.on ? (e.l ^ 16'h8000) : 16'h0000;
            xur = e.on ? (e.r ^ 16'h8000) : 16'h0000;
            checks++;
            if (word_at(bits_s, 1) !== xsl) begin
              errors++;
              $display("FAIL s_left at %0t: got %h want %h", $time, word_at(bits_s, 1), xsl);
            end
            checks++;
            if (word_at(bits_s, 33) !== xsr) begin
              errors++;
              $display("FAIL s_right at %0t: got %h want %h", $time, word_at(bits_s, 33), xsr);
            end
            checks++;
            if (word_at(bits_u, 1) !== xul) begin
              errors++;
              $display("FAIL u_left at %0t: got %h want %h", $time, word_at(bits_u, 1), xul);
            end
            checks++;
            if (word_at(bits_u, 33) !== xur) begin
              errors++;
              $display("FAIL u_right at %0t: got %h want %h", $time, word_at(bits_u, 33), xur);
            end
          end
          checks++;
          if ((pad_or(bits_s) | pad_or(bits_u)) !== 1'b0) begin
            errors++;
            $display("FAIL pad_bits at %0t: got s=%h u=%h want 0 outside p1..16", $time, bits_s, bits_u);
          end
          checks++;
          if (lr_bad) begin
            errors++;
            $display("FAIL lrck at %0t: got mismatch want lrck==cnt[7]", $time);
          end
          checks++;
          if (bck_bad) begin
            errors++;
            $display("FAIL bck at %0t: got mismatch want bck==cnt[1]", $time);
          end
          checks++;
          if (fst_bad) begin
            errors++;
            $display("FAIL frame_st at %0t: got mismatch want pulse at cnt 0", $time);
          end
        end
      end
    end
  end

  task automatic wait_cnt(input logic [7:0] k);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tc !== k && n < 1000);
    checks++;
    if (tc !== k) begin
      errors++;
      $display("FAIL wait_cnt: got tc=%0d want %0d", tc, k);
    end
  endtask

  task automatic strobe_at(
    input logic [7:0]  k,
    input logic [15:0] l,
    input logic [15:0] r
  );
    wait_cnt(k);
    snd_left   = l;
    snd_right  = r;
    snd_sample = 1'b1;
    @(negedge clk);
    snd_sample = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({s_bck, s_lrck, s_dac, s_fst} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_s_outs: got %b want 0000", {s_bck, s_lrck, s_dac, s_fst});
    end
    checks++;
    if ({u_bck, u_lrck, u_dac, u_fst} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_u_outs: got %b want 0000", {u_bck, u_lrck, u_dac, u_fst});
    end
    #2 rst_n = 1'b1;
    mon_en = 1;
    sb.push_back('{l: 16'h0, r: 16'h0, on: 1'b0});
    sb.push_back('{l: 16'h0, r: 16'h0, on: 1'b0});
    wait_cnt(8'd0);
    wait_cnt(8'd0);
  endtask

  task automatic test_signed();
    sb.push_back('{l: 16'hA5C3, r: 16'h0001, on: 1'b1});
    strobe_at(8'd10, 16'hA5C3, 16'h0001);
    wait_cnt(8'd0);
  endtask

  task automatic test_unsigned();
    sb.push_back('{l: 16'h8000, r: 16'h8000, on: 1'b1});
    strobe_at(8'd20, 16'h8000, 16'h8000);
    wait_cnt(8'd0);
    sb.push_back('{l: 16'h0000, r: 16'h8000, on: 1'b1});
    strobe_at(8'd20, 16'h0000, 16'h8000);
    wait_cnt(8'd0);
  endtask

  task automatic test_simul_load();
    sb.push_back('{l: 16'hFFFF, r: 16'hFFFF, on: 1'b1});
    strobe_at(8'd30, 16'hFFFF, 16'hFFFF);
    wait_cnt(8'd0);
    strobe_at(8'd255, 16'h1234, 16'h4321);
    sb.push_back('{l: 16'hFFFF, r: 16'hFFFF, on: 1'b1});
    sb.push_back('{l: 16'h1234, r: 16'h4321, on: 1'b1});
    wait_cnt(8'd0);
  endtask

  task automatic test_back_to_back();
    wait_cnt(8'd40);
    snd_sample = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      snd_left  = 16'(i);
      snd_right = 16'(i);
      @(negedge clk);
    end
    snd_sample = 1'b0;
    repeat (5) sb.push_back('{l: 16'h0003, r: 16'h0003, on: 1'b1});
    repeat (5) wait_cnt(8'd0);
  endtask

  task automatic test_mute();
    sb.push_back('{l: 16'h7FFF, r: 16'h7FFF, on: 1'b1});
    strobe_at(8'd10, 16'h7FFF, 16'h7FFF);
    wait_cnt(8'd0);
    wait_cnt(8'd100);
    mute = 1'b1;
    sb.push_back('{l: 16'h0, r: 16'h0, on: 1'b0});
    sb.push_back('{l: 16'h0, r: 16'h0, on: 1'b0});
    wait_cnt(8'd0);
    wait_cnt(8'd0);
    wait_cnt(8'd50);
    mute = 1'b0;
    wait_cnt(8'd0);
  endtask

  task automatic test_reset_mid();
    wait_cnt(8'd30);
    checks++;
    if ({s_dac, u_dac, s_bck} !== 3'b111) begin
      errors++;
      $display("FAIL unmuted_mid: got dac_s,dac_u,bck=%b want 111", {s_dac, u_dac, s_bck});
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({s_bck, s_lrck, s_dac, s_fst, u_bck, u_lrck, u_dac, u_fst} !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: got %b want 00000000",
               {s_bck, s_lrck, s_dac, s_fst, u_bck, u_lrck, u_dac, u_fst});
    end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    sb.push_back('{l: 16'h0, r: 16'h0, on: 1'b0});
    wait_cnt(8'd0);
    wait_cnt(8'd0);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d left want 0", sb.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_signed();
    test_unsigned();
    test_simul_load();
    test_back_to_back();
    test_mute();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
